// File: rtl/stream_perf_ctrl.sv
// Measurement-window controller for an AXI-Stream passthrough: gates the stream and
// counts beats/cycles over a bounded window. Optional stall counter: STREAM_PERF_STALL_CNT_EN.
module stream_perf_ctrl #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  beat_limit,
  input  logic [CNT_W-1:0]  timeout_limit,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  data_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + ONE;
    end
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cycle_r, cycle_s;
  logic [CNT_W-1:0] data_r, data_s;
  logic [CNT_W-1:0] bl_r, bl_s;
  logic [CNT_W-1:0] tl_r, tl_s;
  logic             timed_out_r, timed_out_s;
  logic             busy_r, done_r;
  logic             beat_s, start_acc_s;
  logic [CNT_W-1:0] cycle_inc_s, data_inc_s;

  // The gate is open exactly while busy; data path is pure passthrough.
  assign m_axis_tvalid = busy_r & s_axis_tvalid;
  assign s_axis_tready = busy_r & m_axis_tready;
  assign m_axis_tdata  = s_axis_tdata;

  assign beat_s      = busy_r & s_axis_tvalid & m_axis_tready;
  assign start_acc_s = start & ~abort & ~busy_r;
  assign cycle_inc_s = sat_inc(cycle_r);
  assign data_inc_s  = sat_inc(data_r);

  // Next-state and next-counter logic; abort dominates, then beat/timeout, then start.
  always_comb begin
    state_s     = state_r;
    cycle_s     = cycle_r;
    data_s      = data_r;
    bl_s        = bl_r;
    tl_s        = tl_r;
    timed_out_s = timed_out_r;
    if (abort) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start_acc_s) begin
            state_s     = ARMED;
            cycle_s     = ZERO;
            data_s      = ZERO;
            timed_out_s = 1'b0;
            bl_s        = (beat_limit == ZERO) ? ONE : beat_limit;
            tl_s        = timeout_limit;
          end else begin
            state_s = state_r;
          end
        end
        ARMED: begin
          if (beat_s) begin
            data_s  = ONE;
            cycle_s = ONE;
            state_s = (bl_r == ONE) ? DONE : RUN;
          end else begin
            state_s = ARMED;
          end
        end
        RUN: begin
          cycle_s = cycle_inc_s;
          if (beat_s) begin
            data_s = data_inc_s;
          end else begin
            data_s = data_r;
          end
          // A final beat outranks a coincident timeout.
          if (beat_s && (data_inc_s == bl_r)) begin
            state_s = DONE;
          end else if ((tl_r != ZERO) && (cycle_inc_s == tl_r)) begin
            state_s     = DONE;
            timed_out_s = 1'b1;
          end else begin
            state_s = RUN;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State, counters, latched limits and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cycle_r     <= ZERO;
      data_r      <= ZERO;
      bl_r        <= ZERO;
      tl_r        <= ZERO;
      timed_out_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cycle_r     <= cycle_s;
      data_r      <= data_s;
      bl_r        <= bl_s;
      tl_r        <= tl_s;
      timed_out_r <= timed_out_s;
      busy_r      <= (state_s == ARMED) || (state_s == RUN);
      done_r      <= (state_s == DONE);
    end
  end

`ifdef STREAM_PERF_STALL_CNT_EN
  logic [CNT_W-1:0] stall_r;
  logic             stall_inc_s;

  assign stall_inc_s = (state_r == RUN) & ~abort & s_axis_tvalid & ~m_axis_tready;

  // Backpressure counter, only while the window is running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_r <= ZERO;
    end else if (start_acc_s) begin
      stall_r <= ZERO;
    end else if (stall_inc_s) begin
      stall_r <= sat_inc(stall_r);
    end else begin
      stall_r <= stall_r;
    end
  end

  assign stall_cnt = stall_r;
`else
  assign stall_cnt = ZERO;
`endif

  assign busy      = busy_r;
  assign done      = done_r;
  assign timed_out = timed_out_r;
  assign cycle_cnt = cycle_r;
  assign data_cnt  = data_r;

endmodule
